// File: rtl/stage_join_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_join_buf_pkg
// Purpose  : Shared RMT pipeline constants used by the stage join buffer.
//            Supplies the PHV width and VLAN ID width that every stage agrees
//            on, so a width change is made in one place.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stage_join_buf_pkg;

  // Packet header vector width shared by all match-action stages.
  localparam int c_RMT_PHV_LEN      = 1024;

  // VLAN ID width carried alongside each PHV.
  localparam int c_RMT_VLANID_WIDTH = 12;

  // Legal range of log2(queue depth) for the join buffer queues.
  localparam int c_DEPTH_BITS_MIN   = 1;
  localparam int c_DEPTH_BITS_MAX   = 6;

endpackage : stage_join_buf_pkg
`default_nettype wire

// File: rtl/stage_join_buf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Generic single-clock fall-through FIFO. The head entry is driven
//            combinationally from storage, so rd_data is valid whenever the
//            FIFO is non-empty and advances on the cycle after rd_en.
// Ports    : axis_clk  - clock
//            aresetn   - synchronous active-low reset (pointers/count only)
//            wr_en     - push request (ignored when full)
//            wr_data   - push data
//            rd_en     - pop request (ignored when empty)
//            rd_data   - head of queue (fall-through)
//            count     - registered occupancy, DEPTH_BITS+1 wide
//            full      - count == DEPTH
//            empty     - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                    c_DEPTH     = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   c_DEPTH_CNT = (DEPTH_BITS+1)'(c_DEPTH);
  localparam logic [DEPTH_BITS:0]   c_CNT_ONE   = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] c_PTR_ONE   = DEPTH_BITS'(1);

  logic [WIDTH-1:0]      r_mem [c_DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full    = (r_count == c_DEPTH_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // Requests are re-qualified locally so the FIFO can never over/underflow
  // even if a caller forgets to gate them.
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  // Storage carries no reset: contents are meaningless while count is zero.
  always_ff @(posedge axis_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly DEPTH_BITS wide, so the increment wraps modulo DEPTH
  // for free.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/stage_join_buf.sv
`default_nettype none
// ============================================================================
// Module   : stage_join_buf
// Purpose  : Joins a PHV stream with an independently arriving VLAN ID stream.
//            Each stream is buffered in its own FIFO; a joined (PHV, VLAN)
//            pair is presented whenever both queues hold an entry, and both
//            heads are popped together on handshake so pairing never skews.
//            VLAN writes are strobes without backpressure: a write into a full
//            VLAN queue is dropped and latched in a sticky overflow flag.
// Ports    : axis_clk      - clock
//            aresetn       - synchronous active-low reset
//            phv_in        - PHV data in
//            phv_in_valid  - PHV valid
//            phv_in_ready  - PHV queue has room
//            vlan_in       - VLAN ID in
//            vlan_valid_in - VLAN write strobe
//            vlan_ready    - advisory: VLAN queue not nearly full
//            phv_out       - head PHV (fall-through)
//            vlan_out      - head VLAN ID (fall-through)
//            out_valid     - both queues non-empty
//            out_ready     - downstream accepts the pair
//            phv_count     - PHV queue occupancy
//            vlan_count    - VLAN queue occupancy
//            vlan_ovf      - sticky VLAN overflow flag
//            ovf_clr       - clears vlan_ovf
// Revision : 1.0 - initial release
// ============================================================================
module stage_join_buf
  import stage_join_buf_pkg::*;
#(
  parameter int PHV_LEN        = c_RMT_PHV_LEN,
  parameter int C_VLANID_WIDTH = c_RMT_VLANID_WIDTH,
  parameter int DEPTH_BITS     = 2
) (
  input  logic                      axis_clk,
  input  logic                      aresetn,

  input  logic [PHV_LEN-1:0]        phv_in,
  input  logic                      phv_in_valid,
  output logic                      phv_in_ready,

  input  logic [C_VLANID_WIDTH-1:0] vlan_in,
  input  logic                      vlan_valid_in,
  output logic                      vlan_ready,

  output logic [PHV_LEN-1:0]        phv_out,
  output logic [C_VLANID_WIDTH-1:0] vlan_out,
  output logic                      out_valid,
  input  logic                      out_ready,

  output logic [DEPTH_BITS:0]       phv_count,
  output logic [DEPTH_BITS:0]       vlan_count,

  output logic                      vlan_ovf,
  input  logic                      ovf_clr
);

  localparam int                  c_DEPTH        = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_NEAR_FULL    = (DEPTH_BITS+1)'(c_DEPTH - 1);

  logic w_phv_full;
  logic w_phv_empty;
  logic w_vlan_full;
  logic w_vlan_empty;
  logic w_phv_push;
  logic w_vlan_push;
  logic w_vlan_drop;
  logic w_pop;
  logic r_vlan_ovf;

  // Ready is derived from the registered occupancy only; a full queue does
  // not accept a write even when a pop happens in the same cycle.
  assign phv_in_ready = !w_phv_full;
  assign vlan_ready   = (vlan_count < c_NEAR_FULL);

  assign w_phv_push   = phv_in_valid && phv_in_ready;
  assign w_vlan_push  = vlan_valid_in && !w_vlan_full;
  assign w_vlan_drop  = vlan_valid_in && w_vlan_full;

  // A pair exists only when both heads are present; both pop together.
  assign out_valid    = !w_phv_empty && !w_vlan_empty;
  assign w_pop        = out_valid && out_ready;

  assign vlan_ovf     = r_vlan_ovf;

  sync_fifo #(
    .WIDTH      (PHV_LEN),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_phv_fifo (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .wr_en    (w_phv_push),
    .wr_data  (phv_in),
    .rd_en    (w_pop),
    .rd_data  (phv_out),
    .count    (phv_count),
    .full     (w_phv_full),
    .empty    (w_phv_empty)
  );

  sync_fifo #(
    .WIDTH      (C_VLANID_WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_vlan_fifo (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .wr_en    (w_vlan_push),
    .wr_data  (vlan_in),
    .rd_en    (w_pop),
    .rd_data  (vlan_out),
    .count    (vlan_count),
    .full     (w_vlan_full),
    .empty    (w_vlan_empty)
  );

  // A same-cycle drop wins over ovf_clr so an overflow is never lost.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      r_vlan_ovf <= 1'b0;
    end else if (w_vlan_drop) begin
      r_vlan_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_vlan_ovf <= 1'b0;
    end
  end

endmodule : stage_join_buf
`default_nettype wire

// File: tb/tb_stage_join_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_join_buf
// Purpose  : Directed self-checking bench for stage_join_buf (DEPTH_BITS=2).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_join_buf;
  import stage_join_buf_pkg::*;

  localparam int PW = c_RMT_PHV_LEN;
  localparam int VW = c_RMT_VLANID_WIDTH;
  localparam int DB = 2;

  logic          axis_clk = 1'b0;
  logic          aresetn;
  logic [PW-1:0] phv_in;
  logic          phv_in_valid;
  logic          phv_in_ready;
  logic [VW-1:0] vlan_in;
  logic          vlan_valid_in;
  logic          vlan_ready;
  logic [PW-1:0] phv_out;
  logic [VW-1:0] vlan_out;
  logic          out_valid;
  logic          out_ready;
  logic [DB:0]   phv_count;
  logic [DB:0]   vlan_count;
  logic          vlan_ovf;
  logic          ovf_clr;

  int checks   = 0;
  int failures = 0;

  always #5 axis_clk = ~axis_clk;

  stage_join_buf #(
    .PHV_LEN        (PW),
    .C_VLANID_WIDTH (VW),
    .DEPTH_BITS     (DB)
  ) dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .phv_in        (phv_in),
    .phv_in_valid  (phv_in_valid),
    .phv_in_ready  (phv_in_ready),
    .vlan_in       (vlan_in),
    .vlan_valid_in (vlan_valid_in),
    .vlan_ready    (vlan_ready),
    .phv_out       (phv_out),
    .vlan_out      (vlan_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .phv_count     (phv_count),
    .vlan_count    (vlan_count),
    .vlan_ovf      (vlan_ovf),
    .ovf_clr       (ovf_clr)
  );

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic idle_inputs();
    phv_in        = '0;
    phv_in_valid  = 1'b0;
    vlan_in       = '0;
    vlan_valid_in = 1'b0;
    out_ready     = 1'b0;
    ovf_clr       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (phv_count !== 3'd0) begin failures++; $display("FAIL reset_phv_count got=%0d exp=0", phv_count); end
    checks++; if (vlan_count !== 3'd0) begin failures++; $display("FAIL reset_vlan_count got=%0d exp=0", vlan_count); end
    checks++; if (vlan_ovf !== 1'b0) begin failures++; $display("FAIL reset_vlan_ovf got=%0b exp=0", vlan_ovf); end
    checks++; if (vlan_ready !== 1'b1) begin failures++; $display("FAIL reset_vlan_ready got=%0b exp=1", vlan_ready); end
    aresetn = 1'b1;
    #1;
    checks++; if (phv_in_ready !== 1'b1) begin failures++; $display("FAIL reset_phv_in_ready got=%0b exp=1", phv_in_ready); end
  endtask

  task automatic test_single_pair();
    do_reset();
    phv_in = PW'(32'hA1); phv_in_valid = 1'b1;
    vlan_in = VW'(12'h005); vlan_valid_in = 1'b1;
    out_ready = 1'b1;
    step();
    phv_in_valid = 1'b0; vlan_valid_in = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pair_out_valid got=%0b exp=1", out_valid); end
    checks++; if (phv_out !== PW'(32'hA1)) begin failures++; $display("FAIL pair_phv_out got=%0h exp=a1", phv_out[63:0]); end
    checks++; if (vlan_out !== VW'(12'h005)) begin failures++; $display("FAIL pair_vlan_out got=%0h exp=5", vlan_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pair_drained_valid got=%0b exp=0", out_valid); end
    checks++; if (phv_count !== 3'd0 || vlan_count !== 3'd0) begin failures++; $display("FAIL pair_drained_counts got=%0d/%0d exp=0/0", phv_count, vlan_count); end
  endtask

  task automatic test_phv_full();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      phv_in = PW'(i); phv_in_valid = 1'b1;
      step();
    end
    checks++; if (phv_count !== 3'd4) begin failures++; $display("FAIL full_phv_count got=%0d exp=4", phv_count); end
    checks++; if (phv_in_ready !== 1'b0) begin failures++; $display("FAIL full_phv_in_ready got=%0b exp=0", phv_in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_out_valid got=%0b exp=0", out_valid); end
    phv_in = PW'(5);
    step();
    phv_in_valid = 1'b0;
    checks++; if (phv_count !== 3'd4) begin failures++; $display("FAIL full_fifth_rejected got=%0d exp=4", phv_count); end
    // Partner already non-empty: one VLAN write makes a pair next cycle.
    vlan_in = VW'(12'h007); vlan_valid_in = 1'b1;
    step();
    vlan_valid_in = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_out_valid got=%0b exp=1", out_valid); end
    checks++; if (phv_out !== PW'(1) || vlan_out !== VW'(12'h007)) begin failures++; $display("FAIL latency_pair got=%0h/%0h exp=1/7", phv_out[63:0], vlan_out); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || phv_count !== 3'd3 || vlan_count !== 3'd0) begin failures++; $display("FAIL joint_pop got=v%0b p%0d q%0d exp=v0 p3 q0", out_valid, phv_count, vlan_count); end
    checks++; if (phv_out !== PW'(2)) begin failures++; $display("FAIL joint_pop_head got=%0h exp=2", phv_out[63:0]); end
  endtask

  task automatic test_vlan_ovf();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      vlan_in = VW'(k); vlan_valid_in = 1'b1;
      step();
      if (k == 2) begin
        checks++; if (vlan_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_after2 got=%0b exp=1", vlan_ready); end
      end
      if (k == 3) begin
        checks++; if (vlan_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready_after3 got=%0b exp=0", vlan_ready); end
      end
      if (k == 4) begin
        checks++; if (vlan_ovf !== 1'b0 || vlan_count !== 3'd4) begin failures++; $display("FAIL ovf_after4 got=f%0b c%0d exp=f0 c4", vlan_ovf, vlan_count); end
      end
    end
    vlan_valid_in = 1'b0;
    checks++; if (vlan_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", vlan_ovf); end
    checks++; if (vlan_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", vlan_count); end
    // Drop and clear in the same cycle: the flag must stay set.
    vlan_in = VW'(9); vlan_valid_in = 1'b1; ovf_clr = 1'b1;
    step();
    vlan_valid_in = 1'b0;
    checks++; if (vlan_ovf !== 1'b1) begin failures++; $display("FAIL ovf_clr_priority got=%0b exp=1", vlan_ovf); end
    step();
    ovf_clr = 1'b0;
    checks++; if (vlan_ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%0b exp=0", vlan_ovf); end
    // Dropped writes must not have disturbed the queued IDs 1..4.
    for (int j = 0; j < 4; j++) begin
      phv_in = PW'(32'h10 + j); phv_in_valid = 1'b1;
      step();
    end
    phv_in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_valid !== 1'b1 || vlan_out !== VW'(j + 1) || phv_out !== PW'(32'h10 + j)) begin
        failures++; $display("FAIL ovf_drain[%0d] got=v%0b %0h/%0h exp=v1 %0h/%0h", j, out_valid, phv_out[63:0], vlan_out, 32'h10 + j, j + 1);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall_order();
    int idx;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      phv_in = PW'(32'h100 + i); phv_in_valid = 1'b1;
      vlan_in = VW'(32'h20 + i); vlan_valid_in = 1'b1;
      step();
    end
    phv_in_valid = 1'b0; vlan_valid_in = 1'b0;
    checks++; if (phv_count !== 3'd4 || vlan_count !== 3'd4) begin failures++; $display("FAIL stall_fill got=%0d/%0d exp=4/4", phv_count, vlan_count); end
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = ((c % 2) == 0);
      checks++;
      if (out_valid !== 1'b1 || phv_out !== PW'(32'h100 + idx) || vlan_out !== VW'(32'h20 + idx)) begin
        failures++; $display("FAIL stall_cycle[%0d] got=v%0b %0h/%0h exp=v1 %0h/%0h", c, out_valid, phv_out[63:0], vlan_out, 32'h100 + idx, 32'h20 + idx);
      end
      step();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || phv_count !== 3'd0 || vlan_count !== 3'd0) begin failures++; $display("FAIL stall_empty got=v%0b %0d/%0d exp=v0 0/0", out_valid, phv_count, vlan_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // out_ready with nothing queued must leave the queues untouched.
    out_ready = 1'b1;
    step();
    checks++; if (phv_count !== 3'd0 || vlan_count !== 3'd0) begin failures++; $display("FAIL idle_ready got=%0d/%0d exp=0/0", phv_count, vlan_count); end
    phv_in = PW'(32'h1000); phv_in_valid = 1'b1;
    vlan_in = VW'(12'h100); vlan_valid_in = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      phv_in = PW'(32'h1000 + c + 1);
      vlan_in = VW'(32'h100 + c + 1);
      checks++;
      if (out_valid !== 1'b1 || phv_out !== PW'(32'h1000 + c) || vlan_out !== VW'(32'h100 + c) ||
          phv_count !== 3'd1 || vlan_count !== 3'd1) begin
        failures++; $display("FAIL stream[%0d] got=v%0b %0h/%0h c%0d/%0d exp=v1 %0h/%0h c1/1", c, out_valid, phv_out[63:0], vlan_out, phv_count, vlan_count, 32'h1000 + c, 32'h100 + c);
      end
      step();
    end
    phv_in_valid = 1'b0; vlan_valid_in = 1'b0;
    checks++; if (phv_out !== PW'(32'h1014) || vlan_out !== VW'(12'h114)) begin failures++; $display("FAIL stream_last got=%0h/%0h exp=1014/114", phv_out[63:0], vlan_out); end
    step();
    out_ready = 1'b0;
    checks++; if (phv_count !== 3'd0 || vlan_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%0d/%0d v%0b exp=0/0 v0", phv_count, vlan_count, out_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      phv_in = PW'(32'h50 + i); phv_in_valid = 1'b1;
      vlan_in = VW'(32'h30 + i); vlan_valid_in = 1'b1;
      step();
    end
    phv_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vlan_in = VW'(32'h40 + i);
      step();
    end
    vlan_valid_in = 1'b0;
    checks++; if (phv_count !== 3'd3 || vlan_count !== 3'd4 || vlan_ovf !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0d/%0d f%0b exp=3/4 f1", phv_count, vlan_count, vlan_ovf); end
    out_ready = 1'b1;
    aresetn = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (phv_count !== 3'd0 || vlan_count !== 3'd0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", phv_count, vlan_count); end
    checks++; if (vlan_ovf !== 1'b0) begin failures++; $display("FAIL midrst_ovf got=%0b exp=0", vlan_ovf); end
    aresetn = 1'b1;
    out_ready = 1'b0;
    step();
  endtask

  initial begin
    aresetn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_pair();
    test_phv_full();
    test_vlan_ovf();
    test_stall_order();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stage_join_buf
`default_nettype wire
